// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, id_ctrl bit map and forward-select encodings
package id_ex_stage_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF = 5;
  localparam int CTRL_W = 9;
  localparam int C_REG_WRITE = 8;
  localparam int C_MEM_READ = 7;
  localparam int C_MEM_WRITE = 6;
  localparam int C_MEM_TO_REG = 5;
  localparam int C_ALU_SRC = 4;
  localparam int C_REG_DST = 3;
  localparam int C_ALU_OP_HI = 2;
  localparam int C_ALU_OP_LO = 0;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the operand source for one EX source register, nearest producer first
module fwd_select
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] src,
  output logic [1:0]       sel
);
  // $0 is hard-wired zero, so a write targeting it is never a producer
  always_comb
    sel = (ex_reg_write && ex_dst != '0 && ex_dst == src) ? FWD_MEM :
          (mem_reg_write && mem_rd != '0 && mem_rd == src) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection and forwarding selects
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_mem_reg_write,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_dst,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              hz_stall,
  output logic [15:0]       stall_count
);
  logic [1:0] fa;
  logic [1:0] fb;
  logic       ex_writes;
  logic       bubble;
  assign ex_writes = ex_valid & ex_ctrl[C_REG_WRITE];
  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .ex_reg_write (ex_writes),
    .ex_dst       (ex_dst),
    .mem_reg_write(ex_mem_reg_write),
    .mem_rd       (ex_mem_rd),
    .src          (id_rs),
    .sel          (fa)
  );
  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .ex_reg_write (ex_writes),
    .ex_dst       (ex_dst),
    .mem_reg_write(ex_mem_reg_write),
    .mem_rd       (ex_mem_rd),
    .src          (id_rt),
    .sel          (fb)
  );
  // load in EX whose result the ID instruction needs; a flush makes the stall moot
  always_comb begin
    hz_stall = id_valid & ex_valid & ex_ctrl[C_MEM_READ] & (ex_dst != '0) &
               ((ex_dst == id_rs) | (ex_dst == id_rt)) & ~flush;
    bubble = flush | hz_stall;
  end
  // pipeline register: freeze on hold, insert zeroed bubble on flush or stall
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      fwd_a_sel   <= FWD_REG;
      fwd_b_sel   <= FWD_REG;
      stall_count <= '0;
    end else if (!hold) begin
      ex_valid    <= id_valid & ~bubble;
      ex_ctrl     <= (id_valid & ~bubble) ? id_ctrl : '0;
      ex_rs_data  <= bubble ? '0 : id_rs_data;
      ex_rt_data  <= bubble ? '0 : id_rt_data;
      ex_imm      <= bubble ? '0 : id_imm;
      ex_rs       <= bubble ? '0 : id_rs;
      ex_rt       <= bubble ? '0 : id_rt;
      ex_dst      <= bubble ? '0 : (id_ctrl[C_REG_DST] ? id_rd : id_rt);
      fwd_a_sel   <= bubble ? FWD_REG : fa;
      fwd_b_sel   <= bubble ? FWD_REG : fb;
      if (hz_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
endmodule
